// File: rtl/calc_port_scheduler.sv
// Four-channel calculator front end: captures cmd/op1/op2 per channel, arbitrates
// round-robin onto one ALU port, and routes tagged ALU results back to the channel.
module calc_port_scheduler #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  req1_cmd_in,
  input  logic [CMD_W-1:0]  req2_cmd_in,
  input  logic [CMD_W-1:0]  req3_cmd_in,
  input  logic [CMD_W-1:0]  req4_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [1:0]        out_resp1,
  output logic [1:0]        out_resp2,
  output logic [1:0]        out_resp3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [CMD_W-1:0]  alu_cmd,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [1:0]        alu_tag,
  input  logic              alu_rsp_valid,
  input  logic [1:0]        alu_rsp_tag,
  input  logic [1:0]        alu_rsp,
  input  logic [DATA_W-1:0] alu_rsp_data,
  output logic [3:0]        cmd_drop,
  output logic              stray_rsp
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OP2  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;
  localparam logic [1:0] ST_BUSY = 2'd3;

  logic [CMD_W-1:0]  cmd_in    [4];
  logic [DATA_W-1:0] data_in   [4];
  logic [1:0]        state_vec [4];
  logic [CMD_W-1:0]  cmd_vec   [4];
  logic [DATA_W-1:0] op1_vec   [4];
  logic [DATA_W-1:0] op2_vec   [4];
  logic [1:0]        resp_vec  [4];
  logic [DATA_W-1:0] rdata_vec [4];
  logic [3:0]        drop_vec;
  logic [3:0]        eligible;

  logic              alu_valid_reg;
  logic [1:0]        alu_tag_reg;
  logic [CMD_W-1:0]  alu_cmd_reg;
  logic [DATA_W-1:0] alu_op1_reg;
  logic [DATA_W-1:0] alu_op2_reg;
  logic [1:0]        ptr_reg;
  logic              stray_reg;
  logic              transfer;
  logic              sel_found;
  logic [1:0]        sel_idx;
  logic [1:0]        search_base;
  logic [1:0]        cand;

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  assign transfer = alu_valid_reg & alu_ready;

  function automatic logic cmd_ok(input logic [CMD_W-1:0] c);
    return (c == CMD_W'(1)) || (c == CMD_W'(2)) || (c == CMD_W'(5)) || (c == CMD_W'(6));
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic [1:0]        state_reg;
      logic [CMD_W-1:0]  cmd_reg;
      logic [DATA_W-1:0] op1_reg;
      logic [DATA_W-1:0] op2_reg;
      logic [1:0]        resp_reg;
      logic [DATA_W-1:0] rdata_reg;
      logic              drop_reg;
      logic              cmd_seen;
      logic              rsp_hit;
      logic              granted;

      assign cmd_seen = (cmd_in[gi] != '0);
      assign rsp_hit  = alu_rsp_valid && (alu_rsp_tag == 2'(gi));
      assign granted  = transfer && (alu_tag_reg == 2'(gi));

      always_ff @(posedge c_clk) begin
        if (reset) begin
          state_reg <= ST_IDLE;
          cmd_reg   <= '0;
          op1_reg   <= '0;
          op2_reg   <= '0;
          resp_reg  <= 2'b00;
          rdata_reg <= '0;
          drop_reg  <= 1'b0;
        end else begin
          resp_reg  <= 2'b00;
          rdata_reg <= '0;
          drop_reg  <= 1'b0;
          case (state_reg)
            ST_IDLE: begin
              if (cmd_seen) begin
                state_reg <= ST_OP2;
                cmd_reg   <= cmd_in[gi];
                op1_reg   <= data_in[gi];
              end
            end
            ST_OP2: begin
              op2_reg  <= data_in[gi];
              drop_reg <= cmd_seen;
              if (cmd_ok(cmd_reg)) begin
                state_reg <= ST_PEND;
              end else begin
                resp_reg  <= 2'b11;
                state_reg <= ST_IDLE;
              end
            end
            ST_PEND: begin
              drop_reg <= cmd_seen;
              if (granted) state_reg <= ST_BUSY;
            end
            default: begin
              // The result edge frees the channel, so a command on that same edge is taken.
              if (rsp_hit) begin
                resp_reg  <= alu_rsp;
                rdata_reg <= (alu_rsp == 2'b01) ? alu_rsp_data : '0;
                if (cmd_seen) begin
                  state_reg <= ST_OP2;
                  cmd_reg   <= cmd_in[gi];
                  op1_reg   <= data_in[gi];
                end else begin
                  state_reg <= ST_IDLE;
                end
              end else begin
                drop_reg <= cmd_seen;
              end
            end
          endcase
        end
      end

      assign state_vec[gi] = state_reg;
      assign cmd_vec[gi]   = cmd_reg;
      assign op1_vec[gi]   = op1_reg;
      assign op2_vec[gi]   = op2_reg;
      assign resp_vec[gi]  = resp_reg;
      assign rdata_vec[gi] = rdata_reg;
      assign drop_vec[gi]  = drop_reg;
      // A valid command in its operand-2 cycle may be issued on that same edge.
      assign eligible[gi]  = (state_reg == ST_PEND) || ((state_reg == ST_OP2) && cmd_ok(cmd_reg));
    end
  endgenerate

  // Round-robin search; the channel leaving on this edge's transfer is excluded.
  always_comb begin
    sel_found   = 1'b0;
    sel_idx     = 2'd0;
    cand        = 2'd0;
    search_base = transfer ? alu_tag_reg : ptr_reg;
    for (int i = 1; i <= 4; i++) begin
      cand = search_base + 2'(i);
      if (!sel_found && eligible[cand] && !(transfer && (cand == alu_tag_reg))) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      alu_valid_reg <= 1'b0;
      alu_tag_reg   <= 2'd0;
      alu_cmd_reg   <= '0;
      alu_op1_reg   <= '0;
      alu_op2_reg   <= '0;
      ptr_reg       <= 2'd3;
      stray_reg     <= 1'b0;
    end else begin
      stray_reg <= alu_rsp_valid && (state_vec[alu_rsp_tag] != ST_BUSY);
      if (transfer) ptr_reg <= alu_tag_reg;
      if (!alu_valid_reg || transfer) begin
        alu_valid_reg <= sel_found;
        if (sel_found) begin
          alu_tag_reg <= sel_idx;
          alu_cmd_reg <= cmd_vec[sel_idx];
          alu_op1_reg <= op1_vec[sel_idx];
          alu_op2_reg <= (state_vec[sel_idx] == ST_OP2) ? data_in[sel_idx] : op2_vec[sel_idx];
        end else begin
          alu_tag_reg <= 2'd0;
          alu_cmd_reg <= '0;
          alu_op1_reg <= '0;
          alu_op2_reg <= '0;
        end
      end
    end
  end

  assign alu_valid = alu_valid_reg;
  assign alu_tag   = alu_tag_reg;
  assign alu_cmd   = alu_cmd_reg;
  assign alu_op1   = alu_op1_reg;
  assign alu_op2   = alu_op2_reg;
  assign stray_rsp = stray_reg;
  assign cmd_drop  = drop_vec;
  assign out_resp1 = resp_vec[0];
  assign out_resp2 = resp_vec[1];
  assign out_resp3 = resp_vec[2];
  assign out_resp4 = resp_vec[3];
  assign out_data1 = rdata_vec[0];
  assign out_data2 = rdata_vec[1];
  assign out_data3 = rdata_vec[2];
  assign out_data4 = rdata_vec[3];

endmodule

// File: tb/tb_calc_port_scheduler.sv
// Bench for calc_port_scheduler: event-level reference model checked every cycle,
// directed scenarios with literal expectations, and an ALU stub (auto or manual).
module tb_calc_port_scheduler;

  logic        c_clk;
  logic        reset;
  logic [3:0]  cmd_in [4];
  logic [31:0] dat_in [4];
  logic [1:0]  o_resp [4];
  logic [31:0] o_data [4];
  logic        alu_valid, alu_ready, alu_rsp_valid, stray_rsp;
  logic [3:0]  alu_cmd, cmd_drop;
  logic [31:0] alu_op1, alu_op2, alu_rsp_data;
  logic [1:0]  alu_tag, alu_rsp_tag, alu_rsp;
  logic [1:0]  r1, r2, r3, r4;
  logic [31:0] d1, d2, d3, d4;

  int total = 0;
  int bad   = 0;
  bit auto_mode;
  int q_tag[$];
  logic [1:0]  q_rsp[$];
  logic [31:0] q_data[$];

  calc_port_scheduler dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd_in[0]), .req2_cmd_in(cmd_in[1]),
    .req3_cmd_in(cmd_in[2]), .req4_cmd_in(cmd_in[3]),
    .req1_data_in(dat_in[0]), .req2_data_in(dat_in[1]),
    .req3_data_in(dat_in[2]), .req4_data_in(dat_in[3]),
    .out_resp1(r1), .out_resp2(r2), .out_resp3(r3), .out_resp4(r4),
    .out_data1(d1), .out_data2(d2), .out_data3(d3), .out_data4(d4),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_cmd(alu_cmd),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_tag(alu_tag),
    .alu_rsp_valid(alu_rsp_valid), .alu_rsp_tag(alu_rsp_tag),
    .alu_rsp(alu_rsp), .alu_rsp_data(alu_rsp_data),
    .cmd_drop(cmd_drop), .stray_rsp(stray_rsp)
  );

  assign o_resp[0] = r1;  assign o_resp[1] = r2;  assign o_resp[2] = r3;  assign o_resp[3] = r4;
  assign o_data[0] = d1;  assign o_data[1] = d2;  assign o_data[2] = d3;  assign o_data[3] = d4;

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  // ALU stub arithmetic: 1 add, 2 sub, 5 xor, 6 or; carry/borrow reports code 10.
  task automatic alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [1:0] r, output logic [31:0] d);
    logic [32:0] wide;
    r = 2'b01;
    d = 32'h0;
    case (c)
      4'd1: begin wide = {1'b0, a} + {1'b0, b}; d = wide[31:0]; if (wide[32]) r = 2'b10; end
      4'd2: begin d = a - b; if (a < b) r = 2'b10; end
      4'd5: d = a ^ b;
      4'd6: d = a | b;
      default: d = 32'h0;
    endcase
  endtask

  // Reference model: each channel is free / waiting for op2 / queued / at the ALU.
  int          m_phase [4];
  logic [3:0]  m_cmd   [4];
  logic [31:0] m_a     [4];
  logic [31:0] m_b     [4];
  int          m_offer, m_last;
  bit          m_live = 0;
  logic [1:0]  e_resp  [4];
  logic [31:0] e_data  [4];
  logic [3:0]  e_drop, e_cmd;
  logic        e_stray;
  logic [31:0] e_op1, e_op2;

  always @(posedge c_clk) begin : model
    int  ph [4];
    int  prev_offer, ch;
    bit  xfer, freed;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_phase[i] = 0; e_resp[i] = 2'b00; e_data[i] = 32'h0;
      end
      e_drop = 4'h0; e_stray = 1'b0; m_offer = -1; m_last = 3; m_live = 1;
    end else if (m_live) begin
      ph = m_phase;
      prev_offer = m_offer;
      xfer = (prev_offer >= 0) && alu_ready;
      e_drop = 4'h0;
      e_stray = 1'b0;
      for (int i = 0; i < 4; i++) begin
        e_resp[i] = 2'b00; e_data[i] = 32'h0;
      end
      if (alu_rsp_valid) begin
        if (ph[alu_rsp_tag] == 3) begin
          e_resp[alu_rsp_tag] = alu_rsp;
          e_data[alu_rsp_tag] = (alu_rsp == 2'b01) ? alu_rsp_data : 32'h0;
          m_phase[alu_rsp_tag] = 0;
        end else begin
          e_stray = 1'b1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        freed = (ph[i] == 3) && (m_phase[i] == 0);
        if (cmd_in[i] != 4'h0) begin
          if (ph[i] == 0 || freed) begin
            m_cmd[i] = cmd_in[i]; m_a[i] = dat_in[i]; m_phase[i] = 1;
          end else begin
            e_drop[i] = 1'b1;
          end
        end
        if (ph[i] == 1) begin
          m_b[i] = dat_in[i];
          if (legal(m_cmd[i])) m_phase[i] = 2;
          else begin
            e_resp[i] = 2'b11; e_data[i] = 32'h0; m_phase[i] = 0;
          end
        end
      end
      if (xfer) begin
        m_phase[prev_offer] = 3;
        m_last = prev_offer;
      end
      if (prev_offer < 0 || xfer) begin
        m_offer = -1;
        for (int k = 1; k <= 4; k++) begin
          ch = (m_last + k) % 4;
          if (m_offer < 0 && !(xfer && ch == prev_offer) &&
              (ph[ch] == 2 || (ph[ch] == 1 && legal(m_cmd[ch]))))
            m_offer = ch;
        end
        if (m_offer >= 0) begin
          e_cmd = m_cmd[m_offer]; e_op1 = m_a[m_offer]; e_op2 = m_b[m_offer];
        end
      end
    end
  end

  always @(negedge c_clk) begin
    if (m_live) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("out_resp%0d", i + 1), o_resp[i], e_resp[i]);
        check($sformatf("out_data%0d", i + 1), o_data[i], e_data[i]);
      end
      check("cmd_drop", cmd_drop, e_drop);
      check("stray_rsp", stray_rsp, e_stray);
      check("alu_valid", alu_valid, m_offer >= 0);
      if (m_offer >= 0) begin
        check("alu_tag", alu_tag, m_offer);
        check("alu_cmd", alu_cmd, e_cmd);
        check("alu_op1", alu_op1, e_op1);
        check("alu_op2", alu_op2, e_op2);
      end
    end
  end

  // One clock: note a transfer for the stub, cross the edge, clear one-shot inputs.
  task automatic tick();
    logic [1:0]  r;
    logic [31:0] d;
    if (reset) begin
      q_tag.delete(); q_rsp.delete(); q_data.delete();
    end else if (auto_mode && alu_valid === 1'b1 && alu_ready) begin
      alu_fn(alu_cmd, alu_op1, alu_op2, r, d);
      q_tag.push_back(alu_tag); q_rsp.push_back(r); q_data.push_back(d);
    end
    @(negedge c_clk);
    for (int i = 0; i < 4; i++) begin
      cmd_in[i] = 4'h0; dat_in[i] = 32'h0;
    end
    alu_rsp_valid = 1'b0; alu_rsp_tag = 2'd0; alu_rsp = 2'b00; alu_rsp_data = 32'h0;
    if (auto_mode && q_tag.size() > 0) begin
      alu_rsp_valid = 1'b1;
      alu_rsp_tag   = 2'(q_tag.pop_front());
      alu_rsp       = q_rsp.pop_front();
      alu_rsp_data  = q_data.pop_front();
    end
  endtask

  task automatic wait_resp(input int ch, input logic [1:0] er, input logic [31:0] ed);
    int n;
    for (n = 0; n < 20; n++) begin
      if (o_resp[ch] != 2'b00) break;
      tick();
    end
    check($sformatf("wait ch%0d response", ch + 1), n < 20, 1);
    check($sformatf("lit out_resp%0d", ch + 1), o_resp[ch], er);
    check($sformatf("lit out_data%0d", ch + 1), o_data[ch], ed);
  endtask

  initial begin
    int tags[$];
    int cnt [4];
    reset = 1'b1; alu_ready = 1'b1; auto_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_in[i] = 4'h0; dat_in[i] = 32'h0; cnt[i] = 0;
    end
    alu_rsp_valid = 1'b0; alu_rsp_tag = 2'd0; alu_rsp = 2'b00; alu_rsp_data = 32'h0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset alu_valid", alu_valid, 0);
    check("reset cmd_drop", cmd_drop, 0);
    check("reset out_resp1", o_resp[0], 0);

    // Single add on ch1: issue two cycles after the command cycle.
    cmd_in[0] = 4'd1; dat_in[0] = 32'h5; tick();
    dat_in[0] = 32'h1; tick();
    check("t1 alu_valid", alu_valid, 1);
    check("t1 alu_tag", alu_tag, 0);
    check("t1 alu_op2", alu_op2, 32'h1);
    tick(); tick();
    check("t1 out_resp1", o_resp[0], 2'b01);
    check("t1 out_data1", o_data[0], 32'h6);
    check("t1 out_resp2", o_resp[1], 0);
    tick();
    check("t1 pulse width", o_resp[0], 0);

    // Fresh pointer, then all four channels at once.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin cmd_in[i] = 4'd2; dat_in[i] = 32'h5; end
    tick();
    for (int i = 0; i < 4; i++) dat_in[i] = 32'h2;
    tick();
    repeat (10) begin
      if (alu_valid) tags.push_back(alu_tag);
      for (int i = 0; i < 4; i++) if (o_resp[i] == 2'b01 && o_data[i] == 32'h3) cnt[i]++;
      tick();
    end
    check("t2 grant count", tags.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2 tag order %0d", k), (k < tags.size()) ? tags[k] : 99, k);
      check($sformatf("t2 ch%0d responses", k + 1), cnt[k], 1);
    end

    // Invalid command answered locally; channel free immediately afterwards.
    cmd_in[1] = 4'hC; dat_in[1] = 32'h1; tick();
    dat_in[1] = 32'h1; tick();
    check("t3 out_resp2", o_resp[1], 2'b11);
    check("t3 out_data2", o_data[1], 0);
    check("t3 alu_valid", alu_valid, 0);
    cmd_in[1] = 4'd1; dat_in[1] = 32'h7; tick();
    check("t3 no drop", cmd_drop, 0);
    dat_in[1] = 32'h8; tick();
    check("t3 reissue tag", alu_tag, 1);
    check("t3 reissue op1", alu_op1, 32'h7);
    wait_resp(1, 2'b01, 32'hF);

    // Stall with ready low: payload for ch3 must hold while ch4 queues up.
    alu_ready = 1'b0;
    cmd_in[2] = 4'd5; dat_in[2] = 32'h10; tick();
    dat_in[2] = 32'h20; tick();
    for (int k = 0; k < 5; k++) begin
      check("t4 stall valid", alu_valid, 1);
      check("t4 stall tag", alu_tag, 2);
      check("t4 stall op1", alu_op1, 32'h10);
      check("t4 stall op2", alu_op2, 32'h20);
      if (k == 0) begin cmd_in[3] = 4'd6; dat_in[3] = 32'h30; end
      if (k == 1) dat_in[3] = 32'h40;
      tick();
    end
    alu_ready = 1'b1; tick();
    check("t4 next tag", alu_tag, 3);
    check("t4 next op2", alu_op2, 32'h40);
    tick();
    wait_resp(2, 2'b01, 32'h30);
    wait_resp(3, 2'b01, 32'h70);
    repeat (2) tick();

    // Manual ALU: drop while busy, out-of-order results, forced zero data, stray tag.
    auto_mode = 1'b0;
    cmd_in[0] = 4'd1; dat_in[0] = 32'h100; cmd_in[1] = 4'd2; dat_in[1] = 32'h50; tick();
    dat_in[0] = 32'h1; dat_in[1] = 32'h10; tick();
    tick(); tick();
    cmd_in[0] = 4'd1; dat_in[0] = 32'h9; tick();
    check("t5 cmd_drop", cmd_drop, 4'b0001);
    alu_rsp_valid = 1'b1; alu_rsp_tag = 2'd1; alu_rsp = 2'b10; alu_rsp_data = 32'hDEAD; tick();
    check("t5 out_resp2", o_resp[1], 2'b10);
    check("t5 out_data2 forced", o_data[1], 0);
    alu_rsp_valid = 1'b1; alu_rsp_tag = 2'd0; alu_rsp = 2'b01; alu_rsp_data = 32'h101;
    cmd_in[0] = 4'd2; dat_in[0] = 32'h20; tick();
    check("t5 out_resp1", o_resp[0], 2'b01);
    check("t5 out_data1", o_data[0], 32'h101);
    check("t5 same-edge accept", cmd_drop, 0);
    alu_rsp_valid = 1'b1; alu_rsp_tag = 2'd3; alu_rsp = 2'b01; alu_rsp_data = 32'h77;
    dat_in[0] = 32'h8; tick();
    check("t5 stray_rsp", stray_rsp, 1);
    check("t5 out_resp4", o_resp[3], 0);
    check("t5 reissue op2", alu_op2, 32'h8);
    auto_mode = 1'b1;
    wait_resp(0, 2'b01, 32'h18);
    repeat (2) tick();

    // Reset while ch1 is at the ALU: late result becomes stray.
    auto_mode = 1'b0;
    cmd_in[0] = 4'd1; dat_in[0] = 32'h3; tick();
    dat_in[0] = 32'h4; tick();
    tick();
    reset = 1'b1; tick();
    check("t6 reset alu_valid", alu_valid, 0);
    tick();
    reset = 1'b0;
    alu_rsp_valid = 1'b1; alu_rsp_tag = 2'd0; alu_rsp = 2'b01; alu_rsp_data = 32'h7; tick();
    check("t6 stray_rsp", stray_rsp, 1);
    check("t6 out_resp1", o_resp[0], 0);
    auto_mode = 1'b1;
    cmd_in[0] = 4'd1; dat_in[0] = 32'hA; tick();
    dat_in[0] = 32'hB; tick();
    wait_resp(0, 2'b01, 32'h15);

    // Underflow: code 10 and data forced to zero.
    cmd_in[3] = 4'd2; dat_in[3] = 32'h1; tick();
    dat_in[3] = 32'h2; tick();
    wait_resp(3, 2'b10, 32'h0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
